switch_event_unit: RTL and testbench
====================================

Name: switch_event_unit

Overview:
- Front end for the simple-processor top level. It replaces the four independent debouncers and the edge-detect logic currently written inline in the top.
- Synchronises and debounces NUM_SW raw pushbuttons and detects releases (falling edges).
- Classifies each press as short or long.
- Presents release events one at a time on a valid/ack handshake. The top consumes these for count, result, ID and state actions.

Parameters:
- NUM_SW, 4, number of switch channels (2..8).
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles needed to accept a level change (10 ms at 25 MHz).
- HOLD_LIMIT, 12500000, held cycles at or above which a press is classed long (0.5 s).

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous reset, active low
- i_Switch  in  NUM_SW  raw asynchronous switch inputs, 1 = pressed
- o_Level  out  NUM_SW  debounced switch levels
- o_Event_Valid  out  1  a release event is pending
- o_Event_Id  out  $clog2(NUM_SW)  index of the presented event
- o_Event_Long  out  1  presented event was a long press
- i_Event_Ack  in  1  consumer accepts the presented event
- o_Overrun  out  1  sticky: a release was lost

Behaviour:
- Reset (i_Rst_L=0, asynchronous): o_Level=0, o_Event_Valid=0, o_Event_Id=0, o_Event_Long=0, o_Overrun=0. All synchroniser flops, debounce counters, hold counters and pending/long bits clear. Reset mid-debounce or with events pending discards everything. No event is generated by reset release even if a switch is held; such a switch debounces to 1 normally.
- Synchroniser: two flops per channel (sync_q). No logic sits between the two flops.
- Debounce, per channel:
  - db_cnt increments each cycle sync_q != o_Level.
  - When sync_q != o_Level and db_cnt == DEBOUNCE_LIMIT-1, o_Level flips at the next edge and db_cnt clears.
  - Any cycle with sync_q == o_Level clears db_cnt.
  - Latency: a raw step held stable changes o_Level exactly 2+DEBOUNCE_LIMIT cycles after the first sampling edge.
- Hold counter, per channel:
  - Clears on the cycle o_Level rises 0->1.
  - Increments while o_Level=1 and saturates at HOLD_LIMIT.
- Release detect: o_Level 1->0 is a release. On the same edge the channel's pending bit sets and its long bit captures (hold_cnt >= HOLD_LIMIT).
- Presentation:
  - o_Event_Valid = OR of pending bits.
  - o_Event_Id = lowest-index pending channel (fixed priority); o_Event_Long = that channel's long bit. All outputs are registered or decoded only from registered state.
  - Id and Long are stable while Valid=1 and no ack occurs, unless a lower-index channel becomes pending; preemption by a lower index is allowed.
- Handshake:
  - i_Event_Ack sampled with o_Event_Valid=1 clears the presented channel's pending bit at that edge.
  - The next event, if any, is presented the following cycle. Maximum throughput is one event per cycle.
  - Ack with Valid=0 is ignored.
- Simultaneous releases: all set pending in the same cycle and are served lowest index first.
- Ack and new release on the same channel in the same cycle: the pending bit stays set with the new long bit. This is not an overrun.
- Release on a channel whose pending bit is already set (no ack that cycle): o_Overrun sets, the old event is kept, the new one is dropped. o_Overrun clears only by reset.
- Glitches shorter than DEBOUNCE_LIMIT cycles never change o_Level and never create events.

Decomposition:
- Package switch_event_pkg holds:
  - default constants DEBOUNCE_LIMIT_DEF and HOLD_LIMIT_DEF;
  - function clog2_min1, returning a width of at least 1;
  - SIM_DEBOUNCE=4 and SIM_HOLD=16 for benches.
- Sub-module switch_debounce_ch: one channel containing the synchroniser, db_cnt, o_Level bit, hold_cnt, and registered release-pulse and long-flag outputs. Instantiated NUM_SW times in a generate loop.
- The top holds the pending/long registers, priority encoder, handshake and overrun logic.

Test Plan (NUM_SW=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=16):
1. Assert i_Rst_L=0 with i_Switch=4'b1111, release at cycle 3 -> all outputs 0 during reset. o_Level=4'b1111 at cycle 3+6, with no event.
2. Press switch 1 for 10 cycles, then release and hold 0 -> o_Level[1] rises 6 cycles after press and falls 6 after release. Valid=1, Id=1, Long=0. Ack one cycle later -> Valid=0 next cycle.
3. Hold switch 2 for 40 cycles, then release -> Valid=1, Id=2, Long=1.
4. Toggle switch 0 every 3 cycles for 30 cycles (bounce) -> o_Level[0] unchanged, no Valid.
5. Release switches 3 and 0 on the same cycle with Ack held high -> Id=0 then Id=3 on consecutive cycles, then Valid=0.
6. Release switch 1 twice with no ack in between -> o_Overrun=1 at the second release. Id=1 is still presented. Ack -> Valid=0, o_Overrun stays 1 until reset.

Source files
------------

// File: rtl/switch_event_pkg.sv
// Shared constants and helpers for the switch event front end.
package switch_event_pkg;

  // Silicon defaults at 25 MHz: 10 ms debounce, 0.5 s long-press threshold.
  localparam int unsigned DEBOUNCE_LIMIT_DEF = 250000;
  localparam int unsigned HOLD_LIMIT_DEF     = 12500000;

  // Short limits that keep simulation runs small.
  localparam int unsigned SIM_DEBOUNCE = 4;
  localparam int unsigned SIM_HOLD     = 16;

  // Width needed to index/count 'value' states, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: two-flop synchroniser, debounce counter, debounced
// level, press-duration counter and release/long indications.
module switch_debounce_ch
  import switch_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter int unsigned HOLD_LIMIT     = HOLD_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic level_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DbW   = clog2_min1(DEBOUNCE_LIMIT);
  localparam int unsigned HoldW = clog2_min1(HOLD_LIMIT + 1);

  logic             sync_meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic             level_flip;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  // Debounce: count consecutive disagreeing cycles, adopt the new level on the last one.
  always_comb begin
    db_cnt_d   = '0;
    level_d    = level_q;
    level_flip = 1'b0;
    if (sync_q != level_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_LIMIT - 1)) begin
        level_flip = 1'b1;
        level_d    = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Press duration: restart on the rising level edge, saturate at the long threshold.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (level_flip && !level_q) begin
      hold_cnt_d = '0;
    end else if (level_q && (hold_cnt_q != HoldW'(HOLD_LIMIT))) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Channel state; the synchroniser pair has nothing between the flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      level_q     <= 1'b0;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      sync_meta_q <= sw_i;
      sync_q      <= sync_meta_q;
      level_q     <= level_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Release/long are decoded purely from this channel's flops so the top can
  // capture the event on the same edge the level falls.
  always_comb begin
    level_o   = level_q;
    release_o = level_flip & level_q;
    long_o    = (hold_cnt_q >= HoldW'(HOLD_LIMIT));
  end

endmodule

// File: rtl/switch_event_unit.sv
// Switch front end: per-channel debounce plus a pending-event queue that
// presents releases one at a time, lowest channel first, on valid/ack.
module switch_event_unit
  import switch_event_pkg::*;
#(
  parameter int unsigned NUM_SW         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter int unsigned HOLD_LIMIT     = HOLD_LIMIT_DEF
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic [NUM_SW-1:0]             i_Switch,
  output logic [NUM_SW-1:0]             o_Level,
  output logic                          o_Event_Valid,
  output logic [clog2_min1(NUM_SW)-1:0] o_Event_Id,
  output logic                          o_Event_Long,
  input  logic                          i_Event_Ack,
  output logic                          o_Overrun
);

  localparam int unsigned IdW = clog2_min1(NUM_SW);

  logic [NUM_SW-1:0] rel;
  logic [NUM_SW-1:0] rel_long;
  logic [NUM_SW-1:0] pending_q, pending_d;
  logic [NUM_SW-1:0] long_q, long_d;
  logic              overrun_q, overrun_d;
  logic [IdW-1:0]    sel_id;
  logic              sel_valid;
  logic              ack_fire;

  for (genvar g = 0; g < NUM_SW; g++) begin : gen_ch
    switch_debounce_ch #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .HOLD_LIMIT    (HOLD_LIMIT)
    ) u_ch (
      .clk_i    (i_Clk),
      .rst_ni   (i_Rst_L),
      .sw_i     (i_Switch[g]),
      .level_o  (o_Level[g]),
      .release_o(rel[g]),
      .long_o   (rel_long[g])
    );
  end

  // Fixed-priority select: lowest pending index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_id = IdW'(i);
    end
    sel_valid = |pending_q;
    ack_fire  = i_Event_Ack & sel_valid;
  end

  // Pending/long update: ack frees the presented slot first, so a release on the
  // same channel in the same cycle refills it instead of counting as lost.
  always_comb begin
    pending_d = pending_q;
    long_d    = long_q;
    overrun_d = overrun_q;
    if (ack_fire) pending_d[sel_id] = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (rel[i]) begin
        if (pending_d[i]) begin
          overrun_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          long_d[i]    = rel_long[i];
        end
      end
    end
  end

  // Event queue state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pending_q <= '0;
      long_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      long_q    <= long_d;
      overrun_q <= overrun_d;
    end
  end

  // Presentation, decoded from registered state only.
  always_comb begin
    o_Event_Valid = sel_valid;
    o_Event_Id    = sel_id;
    o_Event_Long  = sel_valid & long_q[sel_id];
    o_Overrun     = overrun_q;
  end

endmodule

// File: tb/tb_switch_event_unit.sv
// Bench for switch_event_unit: directed scenarios plus randomized switch
// activity, all checked every cycle against a behavioural model.
module tb_switch_event_unit;
  import switch_event_pkg::*;

  localparam int N  = 4;
  localparam int DB = SIM_DEBOUNCE;
  localparam int HL = SIM_HOLD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic         ack;
  logic [N-1:0] level;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic         ev_long;
  logic         overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: synchroniser image, debounced level, and event slots.
  bit [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_long;
  bit         m_ovr;
  int         m_dis  [N];  // consecutive cycles the synced input disagreed with the level
  int         m_high [N];  // cycles the level has been visibly high

  always #5 clk = ~clk;

  switch_event_unit #(
    .NUM_SW        (N),
    .DEBOUNCE_LIMIT(SIM_DEBOUNCE),
    .HOLD_LIMIT    (SIM_HOLD)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw),
    .o_Level      (level),
    .o_Event_Valid(ev_valid),
    .o_Event_Id   (ev_id),
    .o_Event_Long (ev_long),
    .i_Event_Ack  (ack),
    .o_Overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_long = '0; m_ovr = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_dis[c]  = 0;
      m_high[c] = 0;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at it.
  task automatic model_clock();
    int         pid;
    bit [N-1:0] n_pend, n_long;
    pid    = lowest(m_pend);
    n_pend = m_pend;
    n_long = m_long;
    if (ack && pid >= 0) n_pend[pid] = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (m_s2[c] != m_lvl[c]) m_dis[c]++;
      else m_dis[c] = 0;
      if (m_dis[c] == DB) begin
        m_dis[c] = 0;
        m_lvl[c] = m_s2[c];
        if (m_lvl[c]) begin
          m_high[c] = 1;
        end else if (n_pend[c]) begin
          m_ovr = 1'b1;
        end else begin
          n_pend[c] = 1'b1;
          // The hardware counter reads 0 in the first high cycle.
          n_long[c] = (m_high[c] - 1) >= HL;
        end
      end else if (m_lvl[c]) begin
        m_high[c]++;
      end
    end
    m_pend = n_pend;
    m_long = n_long;
    m_s2   = m_s1;
    m_s1   = sw;
  endtask

  task automatic check_outputs();
    int pid;
    check_eq("level", level, m_lvl);
    check_eq("valid", ev_valid, |m_pend);
    check_eq("overrun", overrun, m_ovr);
    pid = lowest(m_pend);
    if (pid >= 0) begin
      check_eq("id", ev_id, pid);
      check_eq("long", ev_long, m_long[pid]);
    end
    if (!rst_n) begin
      check_eq("rst_id", ev_id, 0);
      check_eq("rst_long", ev_long, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clock();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int dur [N];

  initial begin
    rst_n = 1'b0;
    sw    = 4'b1111;
    ack   = 1'b0;
    model_reset();

    // 1: reset with all switches held, then release; levels follow, no event.
    ticks(3);
    check_eq("t1_rst_level", level, 4'b0000);
    check_eq("t1_rst_valid", ev_valid, 0);
    rst_n = 1'b1;
    ticks(5);
    check_eq("t1_level_early", level, 4'b0000);
    tick();
    check_eq("t1_level", level, 4'b1111);
    check_eq("t1_no_event", ev_valid, 0);
    sw  = 4'b0000;
    ack = 1'b1;
    ticks(16);
    ack = 1'b0;
    check_eq("t1_drained", ev_valid, 0);

    // 2: short press on switch 1.
    sw[1] = 1'b1;
    ticks(5);
    check_eq("t2_rise_early", level[1], 0);
    tick();
    check_eq("t2_rise", level[1], 1);
    ticks(4);
    sw[1] = 1'b0;
    ticks(6);
    check_eq("t2_fall", level[1], 0);
    check_eq("t2_valid", ev_valid, 1);
    check_eq("t2_id", ev_id, 1);
    check_eq("t2_long", ev_long, 0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("t2_acked", ev_valid, 0);

    // 3: long press on switch 2.
    sw[2] = 1'b1;
    ticks(40);
    sw[2] = 1'b0;
    ticks(6);
    check_eq("t3_valid", ev_valid, 1);
    check_eq("t3_id", ev_id, 2);
    check_eq("t3_long", ev_long, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 4: bounce on switch 0 faster than the debounce window.
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      ticks(3);
    end
    ticks(6);
    check_eq("t4_level", level[0], 0);
    check_eq("t4_no_event", ev_valid, 0);

    // 5: simultaneous release on 3 and 0 with ack held high.
    sw = 4'b1001;
    ticks(20);
    ack = 1'b1;
    sw  = 4'b0000;
    ticks(6);
    check_eq("t5_first_id", ev_id, 0);
    check_eq("t5_first_valid", ev_valid, 1);
    tick();
    check_eq("t5_second_id", ev_id, 3);
    check_eq("t5_second_valid", ev_valid, 1);
    tick();
    check_eq("t5_empty", ev_valid, 0);
    ack = 1'b0;

    // 6: two releases on switch 1 without an ack -> overrun.
    sw[1] = 1'b1;
    ticks(10);
    sw[1] = 1'b0;
    ticks(10);
    check_eq("t6_no_overrun", overrun, 0);
    sw[1] = 1'b1;
    ticks(10);
    sw[1] = 1'b0;
    ticks(6);
    check_eq("t6_overrun", overrun, 1);
    check_eq("t6_id", ev_id, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("t6_acked", ev_valid, 0);
    ticks(5);
    check_eq("t6_sticky", overrun, 1);
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_clear", overrun, 0);
    rst_n = 1'b1;
    ticks(2);

    // Randomized switch activity with glitches, varying ack pressure, one mid-run reset.
    for (int c = 0; c < N; c++) dur[c] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++) begin
        dur[c]--;
        if (dur[c] == 0) begin
          sw[c]  = ~sw[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
      end
      ack = ($urandom_range(0, 99) < ((n < 1500) ? 50 : 8));
      if (n == 2000) rst_n = 1'b0;
      if (n == 2003) rst_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
